// File: rtl/sysref_sync_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : sysref_sync_sequencer
// Brief   : Arms, aligns and releases a synchronous start across JESD links by
//           gating a programmed number of SYSREF edges and pulsing sync_start.
// Revision: 1.0 - initial release
// ============================================================================
module sysref_sync_sequencer #(
    parameter int NUM_LINKS   = 4,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic                 ext_sync_mode,
    input  logic [3:0]           sysref_count,
    input  logic [TIMEOUT_W-1:0] timeout,
    input  logic                 ext_sync,
    input  logic                 sysref,
    input  logic [NUM_LINKS-1:0] links_ready,
    output logic                 sysref_out,
    output logic                 sync_start,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 link_err
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ARMED       = 3'd1,
        S_WAIT_EXT    = 3'd2,
        S_WAIT_SYSREF = 3'd3,
        S_DRAIN       = 3'd4,
        S_RELEASE     = 3'd5
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_ext_sync_meta;
    logic                   r_sysref_q;
    logic [3:0]             r_edge_target;
    logic [3:0]             r_edge_cnt;
    logic [TIMEOUT_W-1:0]   r_timeout;
    logic [TIMEOUT_W-1:0]   r_tcnt;
    logic                   r_sysref_out;
    logic                   r_sync_start;
    logic                   r_done;
    logic                   r_timeout_err;
    logic                   r_link_err;

    logic       w_ext_edge;
    logic       w_sysref_edge;
    logic       w_links_up;
    logic       w_gate_open;
    logic       w_tmo_active;
    logic       w_link_watch;
    logic       w_timed_out;
    logic       w_link_lost;
    logic       w_abort;
    logic       w_tcnt_max;
    logic [3:0] w_edge_cnt_nxt;

    assign w_ext_edge     = r_ext_sync_meta[SYNC_STAGES-2] & ~r_ext_sync_meta[SYNC_STAGES-1];
    assign w_sysref_edge  = sysref & ~r_sysref_q;
    assign w_links_up     = &links_ready;
    assign w_gate_open    = (r_state == S_WAIT_SYSREF) || (r_state == S_DRAIN);
    assign w_link_watch   = (r_state == S_WAIT_EXT) || w_gate_open;
    assign w_tmo_active   = (r_state == S_ARMED) || w_link_watch;
    assign w_timed_out    = w_tmo_active && (r_timeout != '0) && (r_tcnt == r_timeout);
    assign w_link_lost    = w_link_watch && !w_links_up;
    assign w_abort        = (r_state != S_IDLE) && (disarm || w_link_lost || w_timed_out);
    assign w_tcnt_max     = &r_tcnt;
    assign w_edge_cnt_nxt = r_edge_cnt + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ext_sync_meta <= '0;
            r_sysref_q      <= 1'b0;
            r_edge_target   <= 4'd1;
            r_edge_cnt      <= '0;
            r_timeout       <= '0;
            r_tcnt          <= '0;
            r_sysref_out    <= 1'b0;
            r_sync_start    <= 1'b0;
            r_done          <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_link_err      <= 1'b0;
        end else begin
            r_sysref_q      <= sysref;
            r_ext_sync_meta <= {r_ext_sync_meta[SYNC_STAGES-2:0], ext_sync};
            r_sysref_out    <= sysref & w_gate_open;
            r_sync_start    <= 1'b0;
            if (!w_tcnt_max) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            // Aborts share one exit; disarm is silent, link loss outranks timeout.
            if (w_abort) begin
                r_state <= S_IDLE;
                r_tcnt  <= '0;
                if (!disarm) begin
                    if (w_link_lost) begin
                        r_link_err <= 1'b1;
                    end else begin
                        r_timeout_err <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tcnt <= '0;
                        if (arm && !disarm) begin
                            r_state       <= S_ARMED;
                            r_edge_target <= (sysref_count == 4'd0) ? 4'd1 : sysref_count;
                            r_timeout     <= timeout;
                            r_edge_cnt    <= '0;
                            r_done        <= 1'b0;
                            r_timeout_err <= 1'b0;
                            r_link_err    <= 1'b0;
                        end
                    end
                    S_ARMED: begin
                        if (w_links_up) begin
                            r_state <= ext_sync_mode ? S_WAIT_EXT : S_WAIT_SYSREF;
                            r_tcnt  <= '0;
                        end
                    end
                    S_WAIT_EXT: begin
                        if (w_ext_edge) begin
                            r_state <= S_WAIT_SYSREF;
                            r_tcnt  <= '0;
                        end
                    end
                    S_WAIT_SYSREF: begin
                        if (w_sysref_edge) begin
                            r_edge_cnt <= w_edge_cnt_nxt;
                            if (w_edge_cnt_nxt == r_edge_target) begin
                                r_state <= S_DRAIN;
                                r_tcnt  <= '0;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (!sysref) begin
                            r_state      <= S_RELEASE;
                            r_sync_start <= 1'b1;
                            r_tcnt       <= '0;
                        end
                    end
                    S_RELEASE: begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_tcnt  <= '0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign sysref_out  = r_sysref_out;
    assign sync_start  = r_sync_start;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign link_err    = r_link_err;

endmodule
`default_nettype wire

// File: doc/sysref_sync_sequencer.md
Name: sysref_sync_sequencer

Overview:
- Per-device-clock controller that arms, aligns and releases a synchronous start across NUM_LINKS JESD links of a multi-MxFE system.
- Waits for all links ready, an optional external sync request (ext_sync), then a programmed number of SYSREF rising edges.
- Gates SYSREF to the link layer during that window and emits a single-cycle sync_start to the TPL/DMA.
- Sits between the clock/SYSREF source and the JESD RX/TX link and transport cores; configured through the up_ register layer.

Parameters:
NUM_LINKS, 4, number of link-ready inputs monitored
SYNC_STAGES, 3, synchronizer flops on ext_sync (min 2)
TIMEOUT_W, 16, width of timeout counter/config

Ports:
clk  input  1  device clock; all logic synchronous to it
reset  input  1  asynchronous, active-high reset
arm  input  1  single-cycle request to start a sequence
disarm  input  1  single-cycle abort request
ext_sync_mode  input  1  1: wait for ext_sync edge; 0: skip WAIT_EXT
sysref_count  input  4  SYSREF rising edges to pass (0 treated as 1); sampled on arm
timeout  input  TIMEOUT_W  max cycles per waiting state, 0 = disabled; sampled on arm
ext_sync  input  1  asynchronous external sync request
sysref  input  1  SYSREF, already synchronous to clk
links_ready  input  NUM_LINKS  per-link ready/up status
sysref_out  output  1  gated SYSREF to link layer
sync_start  output  1  one-cycle synchronous start pulse
busy  output  1  high when state != IDLE
done  output  1  sticky; sequence completed; cleared on accepted arm
timeout_err  output  1  sticky; cleared on accepted arm
link_err  output  1  sticky; links dropped mid-sequence; cleared on accepted arm

Behaviour:
- Reset: state IDLE, all outputs 0, counters 0, synchronizer flops 0.
- ext_sync: SYNC_STAGES-flop synchronizer, then rising-edge detect on last two stages. sysref: one register stage; edge = sysref & ~sysref_q.
- States: IDLE -> ARMED -> WAIT_EXT -> WAIT_SYSREF -> DRAIN -> RELEASE -> IDLE.
- IDLE: arm moves to ARMED, latches sysref_count/timeout, clears done/timeout_err/link_err.
- ARMED: stays until &links_ready. Then goes to WAIT_EXT if ext_sync_mode=1, else WAIT_SYSREF.
- WAIT_EXT: synchronized ext_sync rising edge moves to WAIT_SYSREF. Edges in any other state are ignored, not queued.
- WAIT_SYSREF: gate open. Edge counter increments on each sysref edge. The edge making count == N moves to DRAIN.
- DRAIN: gate open until sysref == 0, then RELEASE. A full final pulse always passes.
- RELEASE: sync_start=1 for exactly one cycle, done<=1, next state IDLE.
- sysref_out = registered (sysref & gate_open). 1-cycle latency; 0 whenever gate closed.
- Timeout: cycle counter cleared on every state entry; active in ARMED, WAIT_EXT, WAIT_SYSREF, DRAIN. When counter == timeout (timeout != 0): go IDLE, timeout_err<=1, gate closes next cycle, no sync_start.
- Link loss: any links_ready bit low in WAIT_EXT/WAIT_SYSREF/DRAIN sends the block to IDLE with link_err<=1.
- Priority, same cycle: disarm > link loss > timeout > normal transition.
  - disarm in any state returns IDLE and closes the gate; no flag is set.
  - arm while busy is ignored.
  - arm and disarm together in IDLE: disarm wins, stays IDLE.
- Counter widths: edge counter 4 bits, compared against max(sysref_count,1). Timeout counter TIMEOUT_W bits, saturates, never wraps.
- Async reset mid-sequence: immediate IDLE, sysref_out and sync_start forced 0.

Test Plan:
1. ext_sync_mode=0, sysref_count=2, links_ready=4'hF, SYSREF period 16 clk, arm: exactly 2 SYSREF pulses on sysref_out (1-clk delayed); sync_start single pulse 1 cycle after 2nd pulse falls; done=1, busy=0.
2. ext_sync_mode=1, sysref_count=1, ext_sync pulse 10 ns at 22 us: no sysref_out before ext_sync edge; one pulse after; sync_start once; second ext_sync at 72 us with no arm: no activity.
3. links_ready=4'h7, timeout=100, arm: stays ARMED; at cycle 100 returns IDLE, timeout_err=1, sync_start never asserted.
4. In WAIT_SYSREF after 1 of 3 edges, drop links_ready[2]: IDLE next cycle, link_err=1, sysref_out 0 from following cycle.
5. disarm asserted same cycle as the final counted sysref edge: IDLE, no DRAIN, no sync_start, no flags; subsequent arm restarts cleanly.
6. Assert reset during DRAIN with sysref high: sysref_out/sync_start/busy=0 immediately; after release, arm with sysref_count=0 behaves as count 1.
